// File: rtl/zpc_fetch_queue_if.sv
// Fetch front-end bus: redirect/stall/halt control, instruction-memory port and decoder-facing head.
interface zpc_fetch_queue_if #(
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int PC_WIDTH          = 32,
  parameter int FIFO_DEPTH        = 4
);
  logic                           redirect_valid_i;
  logic [PC_WIDTH-1:0]            redirect_pc_i;
  logic                           stall_valid_i;
  logic                           halt_i;
  logic                           instr_read_enable_o;
  logic [PC_WIDTH-1:0]            instr_read_addr_o;
  logic [INSTRUCTION_WIDTH-1:0]   z_instruction_i;
  logic [INSTRUCTION_WIDTH-1:0]   z_instruction_o;
  logic [PC_WIDTH-1:0]            instr_pc_o;
  logic                           decode_instruction_valid_o;
  logic                           instr_misalign_valid_o;
  logic [PC_WIDTH-1:0]            instr_misalign_addr_o;
  logic [$clog2(FIFO_DEPTH):0]    fifo_count_o;

  modport master (
    input  redirect_valid_i, redirect_pc_i, stall_valid_i, halt_i, z_instruction_i,
    output instr_read_enable_o, instr_read_addr_o, z_instruction_o, instr_pc_o,
           decode_instruction_valid_o, instr_misalign_valid_o, instr_misalign_addr_o, fifo_count_o
  );

  modport slave (
    output redirect_valid_i, redirect_pc_i, stall_valid_i, halt_i, z_instruction_i,
    input  instr_read_enable_o, instr_read_addr_o, z_instruction_o, instr_pc_o,
           decode_instruction_valid_o, instr_misalign_valid_o, instr_misalign_addr_o, fifo_count_o
  );
endinterface

// File: rtl/zpc_fetch_queue.sv
// Instruction fetch queue: strobe -> head valid in 2 cycles, one instr/cycle steady state.
// Stall holds the head; fetch is throttled on queued+in-flight occupancy, so the FIFO never overflows.
module zpc_fetch_queue #(
  parameter int                    INSTRUCTION_WIDTH = 32,
  parameter int                    PC_WIDTH          = 32,
  parameter int                    FIFO_DEPTH        = 4,
  parameter logic [PC_WIDTH-1:0]   RESET_VECTOR      = '0
) (
  input  logic               z_clk,
  input  logic               z_rst,
  zpc_fetch_queue_if.master  bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0]         DEPTH_W = FIFO_DEPTH[CW:0];
  localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);

  typedef enum logic [1:0] {IDLE, RUN, HALT, FAULT} state_t;

  state_t                         state, state_nxt;
  logic [PC_WIDTH-1:0]            fetch_pc, inflight_pc, misalign_addr;
  logic                           inflight, misalign_vld;
  logic [INSTRUCTION_WIDTH-1:0]   mem_instr [FIFO_DEPTH];
  logic [PC_WIDTH-1:0]            mem_pc    [FIFO_DEPTH];
  logic [PW-1:0]                  wr_ptr, rd_ptr;
  logic [CW-1:0]                  count;
  logic                           redirect, misalign, rd_en, push, pop, dec_vld;

  assign redirect = bus.redirect_valid_i;
  assign misalign = redirect && (bus.redirect_pc_i[1:0] != 2'b00);
  // A same-cycle dequeue is deliberately not credited, keeping the issue check off the stall path.
  assign rd_en    = (state == RUN) && !redirect &&
                    (({1'b0, count} + {{CW{1'b0}}, inflight}) < DEPTH_W);
  assign push     = inflight && !redirect;
  assign dec_vld  = (count != '0) && (state != HALT) && !redirect;
  assign pop      = dec_vld && !bus.stall_valid_i;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  state_nxt = RUN;
      RUN:   if (misalign) state_nxt = FAULT; else if (bus.halt_i) state_nxt = HALT;
      HALT:  if (misalign) state_nxt = FAULT; else if (!bus.halt_i) state_nxt = RUN;
      FAULT: if (redirect && !misalign) state_nxt = bus.halt_i ? HALT : RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge z_clk or negedge z_rst) begin
    if (!z_rst) begin
      state         <= IDLE;
      fetch_pc      <= RESET_VECTOR;
      inflight      <= 1'b0;
      inflight_pc   <= '0;
      misalign_vld  <= 1'b0;
      misalign_addr <= '0;
    end else begin
      state        <= state_nxt;
      inflight     <= rd_en;
      misalign_vld <= misalign;
      if (rd_en) inflight_pc <= fetch_pc;
      if (redirect) fetch_pc <= bus.redirect_pc_i;
      else if (rd_en) fetch_pc <= fetch_pc + PC_STEP;
      if (misalign) misalign_addr <= bus.redirect_pc_i;
    end
  end

  // Storage is reset so the head reads as zero out of reset.
  always_ff @(posedge z_clk or negedge z_rst) begin
    if (!z_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_instr[i] <= '0;
        mem_pc[i]    <= '0;
      end
    end else if (redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem_instr[wr_ptr] <= bus.z_instruction_i;
        mem_pc[wr_ptr]    <= inflight_pc;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  assign bus.instr_read_enable_o        = rd_en;
  assign bus.instr_read_addr_o          = fetch_pc;
  assign bus.z_instruction_o            = mem_instr[rd_ptr];
  assign bus.instr_pc_o                 = mem_pc[rd_ptr];
  assign bus.decode_instruction_valid_o = dec_vld;
  assign bus.instr_misalign_valid_o     = misalign_vld;
  assign bus.instr_misalign_addr_o      = misalign_addr;
  assign bus.fifo_count_o               = count;
endmodule
